bitblade_fusion_pe: RTL and testbench

BITBLADE_FUSION_PE -- requirements
Module: bitblade_fusion_pe

---
 rtl/bitblade_pkg.sv | 31 +++
 rtl/bb_mul2x2.sv | 23 ++
 rtl/bitblade_fusion_pe.sv | 214 +++++++++++++++++++++
 tb/tb_bitblade_fusion_pe.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/bitblade_pkg.sv
// Shared encodings for the BitBlade fusion PE: precision modes and chunk geometry.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package bitblade_pkg;

  // Each 8-bit element is split into four 2-bit chunks.
  localparam int CHUNK_W = 2;
  localparam int CHUNKS  = 4;

  typedef enum logic [1:0] {
    MODE_2B = 2'b00,
    MODE_4B = 2'b01,
    MODE_8B = 2'b10
  } mode_e;

  // The reserved encoding 2'b11 behaves as full 8-bit precision.
  function automatic mode_e norm_mode(input logic [1:0] m);
    return (m == 2'b11) ? MODE_8B : mode_e'(m);
  endfunction

  // A chunk carries the sign only when it is the top chunk of its element:
  // every chunk in 2b mode, chunks 1 and 3 in 4b mode, chunk 3 in 8b mode.
  function automatic logic chunk_is_msb(input mode_e m, input int idx);
    case (m)
      MODE_2B: return 1'b1;
      MODE_4B: return (idx % 2) == 1;
      default: return idx == (CHUNKS - 1);
    endcase
  endfunction

endpackage

// File: rtl/bb_mul2x2.sv
// Signed/unsigned 2b x 2b multiplier producing a 6-bit two's-complement product.
// Latency: combinational.
// Backpressure: none (pure datapath).
// Ports: i_a/i_b operand chunks, i_a_sgn/i_b_sgn treat the operand as signed, o_p product.
module bb_mul2x2
  import bitblade_pkg::*;
(
  input  logic [CHUNK_W-1:0]          i_a,
  input  logic [CHUNK_W-1:0]          i_b,
  input  logic                        i_a_sgn,
  input  logic                        i_b_sgn,
  output logic signed [3*CHUNK_W-1:0] o_p
);

  logic signed [3*CHUNK_W-1:0] w_a;
  logic signed [3*CHUNK_W-1:0] w_b;

  // Extend to the product width so the low bits of the product are exact.
  assign w_a = {{(2*CHUNK_W){i_a_sgn & i_a[CHUNK_W-1]}}, i_a};
  assign w_b = {{(2*CHUNK_W){i_b_sgn & i_b[CHUNK_W-1]}}, i_b};
  assign o_p = w_a * w_b;

endmodule

// File: rtl/bitblade_fusion_pe.sv
// Bit-fusion dot-product PE: 2/4/8-bit lane products fused per beat and accumulated per group.
// Latency: result on out_acc three rising edges after the last beat is accepted (S1 pp, S2 beat sum, S3 acc).
// Backpressure: out_valid && !out_ready freezes S1-S3 and drops in_ready.
// Ports: in_valid/in_ready/in_last beat handshake; act/wgt packed lanes; sign_i/sign_w/mode per-beat
//        format; out_valid/out_ready result handshake; out_acc group sum; out_sat saturation flag.
// Config macro: BB_ACC_SAT_EN selects saturating accumulation (otherwise wrap, out_sat tied 0).
module bitblade_fusion_pe
  import bitblade_pkg::*;
#(
  parameter int LANES = 4,
  parameter int ACC_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_last,
  input  logic [8*LANES-1:0] act,
  input  logic [8*LANES-1:0] wgt,
  input  logic               sign_i,
  input  logic               sign_w,
  input  logic [1:0]         mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_acc,
  output logic               out_sat
);

  localparam int PP_W   = 3 * CHUNK_W;
  // 18 bits hold any single 8b x 8b lane product in any sign combination.
  localparam int LANE_W = 18;
  localparam int BEAT_W = LANE_W + $clog2(LANES) + 1;

  logic w_stall;
  logic w_accept;
  mode_e w_mode;
  logic [CHUNKS-1:0] w_a_sgn;
  logic [CHUNKS-1:0] w_b_sgn;
  logic signed [PP_W-1:0] w_pp [LANES][CHUNKS][CHUNKS];

  logic signed [PP_W-1:0] r_pp [LANES][CHUNKS][CHUNKS];
  logic  r_s1_vld;
  logic  r_s1_last;
  mode_e r_s1_mode;

  logic signed [BEAT_W-1:0] w_term;
  logic signed [BEAT_W-1:0] w_beat;
  logic                     r_s2_vld;
  logic                     r_s2_last;
  logic signed [BEAT_W-1:0] r_s2_beat;

  logic signed [ACC_W-1:0] w_res;
  logic signed [ACC_W-1:0] r_acc;
  logic        [ACC_W-1:0] r_out_acc;
  logic                    r_out_vld;

  assign w_stall   = r_out_vld & ~out_ready;
  assign in_ready  = ~w_stall;
  assign w_accept  = in_valid & ~w_stall;
  assign w_mode    = norm_mode(mode);
  assign out_valid = r_out_vld;
  assign out_acc   = r_out_acc;

  always_comb begin
    w_a_sgn = '0;
    w_b_sgn = '0;
    for (int c = 0; c < CHUNKS; c++) begin
      w_a_sgn[c] = sign_i & chunk_is_msb(w_mode, c);
      w_b_sgn[c] = sign_w & chunk_is_msb(w_mode, c);
    end
  end

  // One multiplier per (activation chunk, weight chunk) pair in every lane.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    for (genvar i = 0; i < CHUNKS; i++) begin : g_a
      for (genvar j = 0; j < CHUNKS; j++) begin : g_w
        bb_mul2x2 u_mul (
          .i_a     (act[8*l+CHUNK_W*i +: CHUNK_W]),
          .i_b     (wgt[8*l+CHUNK_W*j +: CHUNK_W]),
          .i_a_sgn (w_a_sgn[i]),
          .i_b_sgn (w_b_sgn[j]),
          .o_p     (w_pp[l][i][j])
        );
      end
    end
  end

  // S1: partial products plus the per-beat control that travels with them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld  <= 1'b0;
      r_s1_last <= 1'b0;
      r_s1_mode <= MODE_8B;
    end else if (!w_stall) begin
      r_s1_vld  <= w_accept;
      r_s1_last <= in_last;
      r_s1_mode <= w_mode;
    end
  end

  // Partial-product data only needs capturing on an accepted beat.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_pp <= w_pp;
    end
  end

  // Fuse partial products according to the beat's precision. In 4b mode only
  // same-nibble pairs contribute; in 2b mode only matching chunk indices do.
  always_comb begin
    w_beat = '0;
    w_term = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int i = 0; i < CHUNKS; i++) begin
        for (int j = 0; j < CHUNKS; j++) begin
          w_term = BEAT_W'(r_pp[l][i][j]);
          case (r_s1_mode)
            MODE_2B: begin
              if (i == j) w_beat = w_beat + w_term;
            end
            MODE_4B: begin
              if ((i / 2) == (j / 2))
                w_beat = w_beat + (w_term <<< (CHUNK_W * ((i % 2) + (j % 2))));
            end
            default: begin
              w_beat = w_beat + (w_term <<< (CHUNK_W * (i + j)));
            end
          endcase
        end
      end
    end
  end

  // S2: fused beat sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_vld  <= 1'b0;
      r_s2_last <= 1'b0;
      r_s2_beat <= '0;
    end else if (!w_stall) begin
      r_s2_vld  <= r_s1_vld;
      r_s2_last <= r_s1_last;
      r_s2_beat <= w_beat;
    end
  end

`ifdef BB_ACC_SAT_EN
  // One guard bit above the wider operand makes the overflow test exact.
  localparam int SUM_W = ((ACC_W > BEAT_W) ? ACC_W : BEAT_W) + 1;
  localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  logic signed [SUM_W-1:0] w_sum;
  logic                    w_ovf;
  logic                    r_sat_grp;
  logic                    r_out_sat;

  always_comb begin
    w_sum = SUM_W'(r_acc) + SUM_W'(r_s2_beat);
    w_ovf = 1'b0;
    w_res = w_sum[ACC_W-1:0];
    if (w_sum > SAT_MAX) begin
      w_res = SAT_MAX[ACC_W-1:0];
      w_ovf = 1'b1;
    end else if (w_sum < SAT_MIN) begin
      w_res = SAT_MIN[ACC_W-1:0];
      w_ovf = 1'b1;
    end
  end

  // Saturation is sticky across the group and reported with its result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_grp <= 1'b0;
      r_out_sat <= 1'b0;
    end else if (!w_stall && r_s2_vld) begin
      if (r_s2_last) begin
        r_out_sat <= r_sat_grp | w_ovf;
        r_sat_grp <= 1'b0;
      end else begin
        r_sat_grp <= r_sat_grp | w_ovf;
      end
    end
  end

  assign out_sat = r_out_sat;
`else
  always_comb begin
    w_res = r_acc + ACC_W'(r_s2_beat);
  end

  assign out_sat = 1'b0;
`endif

  // S3: accumulator is kept at zero between groups, so a group's first beat
  // simply adds to zero. An unstalled cycle means any pending result was taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_out_acc <= '0;
      r_out_vld <= 1'b0;
    end else if (!w_stall) begin
      if (r_s2_vld && r_s2_last) begin
        r_out_acc <= w_res;
        r_out_vld <= 1'b1;
        r_acc     <= '0;
      end else begin
        r_out_vld <= 1'b0;
        if (r_s2_vld) r_acc <= w_res;
      end
    end
  end

endmodule

// File: tb/tb_bitblade_fusion_pe.sv
// Directed bench for bitblade_fusion_pe: a 32-bit accumulator instance and a
// 16-bit instance share the same stimulus; expected values are hand computed.
module tb_bitblade_fusion_pe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_last;
  logic [31:0] act;
  logic [31:0] wgt;
  logic        sign_i;
  logic        sign_w;
  logic [1:0]  mode;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_acc;
  logic        out_sat;

  logic        in_ready16;
  logic        out_valid16;
  logic [15:0] out_acc16;
  logic        out_sat16;

  int n_cmp = 0;
  int n_bad = 0;
  int hs_cnt = 0;
  int hs0;

  always #5 clk = ~clk;

  bitblade_fusion_pe #(.LANES(4), .ACC_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .act(act), .wgt(wgt), .sign_i(sign_i), .sign_w(sign_w),
    .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_sat(out_sat)
  );

  bitblade_fusion_pe #(.LANES(4), .ACC_W(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
    .in_last(in_last), .act(act), .wgt(wgt), .sign_i(sign_i), .sign_w(sign_w),
    .mode(mode), .out_valid(out_valid16), .out_ready(out_ready),
    .out_acc(out_acc16), .out_sat(out_sat16)
  );

  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) hs_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drives one beat at a falling edge; returns at the next falling edge.
  task automatic send(input logic [1:0] m, input logic si, input logic sw,
                      input logic [7:0] a, input logic [7:0] w, input logic last);
    mode     = m;
    sign_i   = si;
    sign_w   = sw;
    act      = {4{a}};
    wgt      = {4{w}};
    in_last  = last;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; act = '0; wgt = '0;
    sign_i = 1'b0; sign_w = 1'b0; mode = 2'b10; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_acc",   out_acc, 32'd0);
    chk("rst_sat",   {31'd0, out_sat}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // 8b signed: -1 * 2 per lane -> -8, visible after the third edge.
    send(2'b10, 1'b1, 1'b1, 8'hFF, 8'h02, 1'b1);
    chk("lat1_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("lat2_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("s8_valid", {31'd0, out_valid}, 32'd1);
    chk("s8_acc",   out_acc, 32'hFFFF_FFF8);
    @(negedge clk);
    chk("s8_clear", {31'd0, out_valid}, 32'd0);

    // 2b unsigned: 4 chunks * 9 * 4 lanes = 144.
    send(2'b00, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1);
    repeat (2) @(negedge clk);
    chk("u2_acc", out_acc, 32'd144);

    // 4b: act nibbles -8 and -1 (signed), weights 1 and 1 -> -9 per lane.
    send(2'b01, 1'b1, 1'b0, 8'h8F, 8'h11, 1'b1);
    repeat (2) @(negedge clk);
    chk("m4_acc", out_acc, 32'hFFFF_FFDC);

    // Mode 11 behaves as 8b.
    send(2'b11, 1'b1, 1'b1, 8'hFF, 8'h02, 1'b1);
    repeat (2) @(negedge clk);
    chk("m11_acc", out_acc, 32'hFFFF_FFF8);

    // Back-to-back single-beat groups: one result per cycle.
    send(2'b10, 1'b1, 1'b1, 8'hFF, 8'h02, 1'b1);
    send(2'b00, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1);
    @(negedge clk);
    chk("b2b_first",  out_acc, 32'hFFFF_FFF8);
    @(negedge clk);
    chk("b2b_second", out_acc, 32'd144);
    chk("b2b_valid",  {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    chk("b2b_done",   {31'd0, out_valid}, 32'd0);

    // Mixed-mode group with a bubble: -8 + 144 = 136.
    send(2'b10, 1'b1, 1'b1, 8'hFF, 8'h02, 1'b0);
    @(negedge clk);
    send(2'b00, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1);
    repeat (2) @(negedge clk);
    chk("mix_acc", out_acc, 32'd136);

    // Three-beat group under a 5-cycle stall: 432 held, a single handshake.
    @(negedge clk);
    out_ready = 1'b0;
    hs0 = hs_cnt;
    send(2'b00, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b0);
    send(2'b00, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b0);
    send(2'b00, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk("stall_acc",   out_acc, 32'd432);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_rdy",   {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_drain", {31'd0, out_valid}, 32'd0);
    chk("stall_hs",    32'(hs_cnt - hs0), 32'd1);
    chk("stall_hold",  out_acc, 32'd432);

    // 8b unsigned 255*255*4 = 260100: wraps or saturates in 16 bits.
    send(2'b10, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1);
    repeat (2) @(negedge clk);
    chk("wide_acc", out_acc, 32'h0003_F804);
    chk("w16_valid", {31'd0, out_valid16}, 32'd1);
`ifdef BB_ACC_SAT_EN
    chk("w16_acc", {16'd0, out_acc16}, 32'h0000_7FFF);
    chk("w16_sat", {31'd0, out_sat16}, 32'd1);
`else
    chk("w16_acc", {16'd0, out_acc16}, 32'h0000_F804);
    chk("w16_sat", {31'd0, out_sat16}, 32'd0);
`endif
    @(negedge clk);

    // Reset in the middle of a three-beat group discards it.
    send(2'b00, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b0);
    send(2'b00, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_acc",   out_acc, 32'd0);
    chk("mid_rst_acc16", {16'd0, out_acc16}, 32'd0);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_sat16", {31'd0, out_sat16}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rdy", {31'd0, in_ready}, 32'd1);
    send(2'b01, 1'b1, 1'b0, 8'h8F, 8'h11, 1'b1);
    repeat (2) @(negedge clk);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
    chk("post_rst_acc",   out_acc, 32'hFFFF_FFDC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
